// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_pkg;

    localparam logic [31:0] DefResetPc   = 32'h0000_3000;
    localparam logic [31:0] DefExcVector = 32'h0000_4180;

    typedef enum logic [1:0] {
        StBoot,
        StIdle,
        StBusy,
        StHold
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        adel;
    } fetch_slot_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_slot_buf.sv
// Two-entry fetch output buffer: presented output register backed by one skid entry.
module if_slot_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  fetch_slot_t push_slot_i,
    input  logic        pop_i,
    output fetch_slot_t out_slot_o,
    output logic        out_valid_o,
    output logic        full_o
);

    fetch_slot_t out_q, out_d;
    fetch_slot_t skid_q, skid_d;
    logic        out_v_q, out_v_d;
    logic        skid_v_q, skid_v_d;

    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            // A push alongside a flush injects a slot directly (address-error bubble).
            skid_v_d = 1'b0;
            out_v_d  = push_i;
            if (push_i) begin
                out_d = push_slot_i;
            end
        end else begin
            if (pop_i) begin
                out_v_d = 1'b0;
            end
            if (pop_i && skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end
            if (push_i) begin
                if ((!out_v_q || pop_i) && !(pop_i && skid_v_q)) begin
                    out_d   = push_slot_i;
                    out_v_d = 1'b1;
                end else begin
                    skid_d   = push_slot_i;
                    skid_v_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign out_slot_o  = out_q;
    assign out_valid_o = out_v_q;
    assign full_o      = skid_v_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-stage PC and instruction-memory request controller (no delay slot).
// Define ALIGN_CHECK_EN to trap misaligned redirect targets to EXC_VECTOR.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefResetPc,
    parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic [31:0] if_instr_o,
    output logic        if_adel_o
);

`ifdef ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    if_state_e   st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        squash_q, squash_d;

    logic        accept, slot_free, buf_full;
    logic        push, flush, misalign;
    logic [31:0] target;
    fetch_slot_t push_slot, fetched, bubble, out_slot;

    assign accept    = if_valid_o & ~stall_i;
    assign slot_free = ~if_valid_o | accept;

    assign imem_req_o  = ((st_q == StIdle) && !buf_full) || (st_q == StBusy);
    assign imem_addr_o = (st_q == StBusy) ? req_addr_q :
                         (st_q == StBoot) ? 32'h0 : pc_q;

    assign misalign = AlignEn && (redirect_pc_i[1:0] != 2'b00);
    assign target   = redirect_pc_i & ~32'h3;

    always_comb begin
        fetched.pc    = imem_addr_o;
        fetched.pc4   = pc_next(imem_addr_o);
        fetched.instr = imem_rdata_i;
        fetched.adel  = 1'b0;
        bubble.pc     = redirect_pc_i;
        bubble.pc4    = pc_next(redirect_pc_i);
        bubble.instr  = 32'h0;
        bubble.adel   = 1'b1;
    end

    always_comb begin
        st_d       = st_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        push       = 1'b0;
        push_slot  = fetched;
        flush      = 1'b0;

        unique case (st_q)
            StBoot: st_d = StIdle;
            StIdle: begin
                if (imem_req_o) begin
                    if (imem_ready_i) begin
                        push = 1'b1;
                        pc_d = pc_next(pc_q);
                        st_d = slot_free ? StIdle : StHold;
                    end else begin
                        req_addr_d = pc_q;
                        st_d       = StBusy;
                    end
                end
            end
            StBusy: begin
                if (imem_ready_i) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        st_d     = StIdle;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_next(req_addr_q);
                        st_d = slot_free ? StIdle : StHold;
                    end
                end
            end
            StHold: begin
                if (accept) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StBoot;
        endcase

        // Redirect wins; an in-flight request must still run to completion, so squash its data.
        if (redirect_valid_i) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = target;
            if (imem_req_o && !imem_ready_i) begin
                st_d     = StBusy;
                squash_d = 1'b1;
            end else begin
                st_d     = StIdle;
                squash_d = 1'b0;
            end
            if (misalign) begin
                push      = 1'b1;
                push_slot = bubble;
                pc_d      = EXC_VECTOR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= StBoot;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            squash_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
        end
    end

    if_slot_buf u_slot_buf (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (push),
        .push_slot_i (push_slot),
        .pop_i       (accept),
        .out_slot_o  (out_slot),
        .out_valid_o (if_valid_o),
        .full_o      (buf_full)
    );

    assign if_pc_o    = out_slot.pc;
    assign if_pc4_o   = out_slot.pc4;
    assign if_instr_o = out_slot.instr;
    assign if_adel_o  = out_slot.adel & AlignEn;

endmodule
